// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HILO multiply/divide path: op codes, write-mask
// encodings, FSM states and the divide iteration count.
package hilo_defs;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [1:0] HILO_WE_NONE = 2'b00;
    localparam logic [1:0] HILO_WE_LO   = 2'b01;
    localparam logic [1:0] HILO_WE_HI   = 2'b10;
    localparam logic [1:0] HILO_WE_BOTH = 2'b11;

    localparam int DIV_ITERS = 32;

    // Register moves need no work state: they finish on the accepting edge
    // and go straight to DONE so their result lands one cycle after start.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } hilo_state_e;

endpackage

// File: rtl/hilo_div_step.sv
// One restoring-divide iteration on unsigned magnitudes: shift the next
// dividend bit into the partial remainder, subtract the divisor if it fits.
module hilo_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_rem,
    input  logic [DATA_W-1:0] i_quo,
    input  logic [DATA_W-1:0] i_dvs,
    output logic [DATA_W-1:0] o_rem,
    output logic [DATA_W-1:0] o_quo
);

    logic [DATA_W:0] w_shift;
    logic [DATA_W:0] w_diff;
    logic            w_fits;

    // Trial subtraction; the quotient register doubles as the dividend shifter.
    always_comb begin
        w_shift = {i_rem, i_quo[DATA_W-1]};
        w_diff  = w_shift - {1'b0, i_dvs};
        w_fits  = (w_shift >= {1'b0, i_dvs});
        o_rem   = w_fits ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
        o_quo   = {i_quo[DATA_W-2:0], w_fits};
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// EX-stage multiply/divide engine producing a masked 64-bit {HI,LO} write.
// Moves finish in 1 cycle, multiplies in MUL_CYCLES, divides in 34.
module hilo_muldiv_unit
    import hilo_defs::*;
#(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [2:0]          op,
    input  logic [DATA_W-1:0]   src_a,
    input  logic [DATA_W-1:0]   src_b,
    input  logic [2*DATA_W-1:0] hilo_cur,
    input  logic                flush,
    output logic                stall_req,
    output logic                busy,
    output logic                done,
    output logic [1:0]          hilo_we,
    output logic [2*DATA_W-1:0] hilo_data
);

    localparam logic [7:0] MUL_LAST = 8'(MUL_CYCLES > 1 ? MUL_CYCLES - 2 : 0);
    localparam logic [7:0] DIV_LAST = 8'(DIV_ITERS - 1);

    hilo_state_e         r_state, w_state_nxt;
    logic [7:0]          r_cnt;
    logic [DATA_W-1:0]   r_a, r_b, r_rem, r_quo, r_dvs;
    logic                r_signed;
    logic                r_done;
    logic [1:0]          r_we;
    logic [2*DATA_W-1:0] r_data;

    logic                w_sgn_in, w_is_mul, w_is_div;
    logic [DATA_W-1:0]   w_a_mag, w_b_mag, w_rem_nxt, w_quo_nxt, w_q, w_r;
    logic                w_ld;
    logic [1:0]          w_we;
    logic [2*DATA_W-1:0] w_data;

    // Sign- or zero-extend both operands and keep the low 2*DATA_W product bits.
    function automatic logic [2*DATA_W-1:0] f_mul(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input logic sgn);
        logic [2*DATA_W-1:0] xa, xb;
        xa = sgn ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
        xb = sgn ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
        return xa * xb;
    endfunction

    // Decode the incoming op and form divide magnitudes from the raw inputs.
    always_comb begin
        w_sgn_in = (op == OP_MULT) || (op == OP_DIV);
        w_is_mul = (op == OP_MULT) || (op == OP_MULTU);
        w_is_div = (op == OP_DIV)  || (op == OP_DIVU);
        w_a_mag  = (w_sgn_in && src_a[DATA_W-1]) ? -src_a : src_a;
        w_b_mag  = (w_sgn_in && src_b[DATA_W-1]) ? -src_b : src_b;
    end

    hilo_div_step #(.DATA_W(DATA_W)) u_div_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_dvs (r_dvs),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    // Quotient is negative when operand signs differ; remainder follows the dividend.
    always_comb begin
        w_q = (r_signed && (r_a[DATA_W-1] ^ r_b[DATA_W-1])) ? -r_quo : r_quo;
        w_r = (r_signed && r_a[DATA_W-1]) ? -r_rem : r_rem;
    end

    // Next state plus the result to register for the following DONE cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_ld        = 1'b0;
        w_we        = HILO_WE_NONE;
        w_data      = '0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_is_div) begin
                        w_state_nxt = ST_DIV;
                    end else if (w_is_mul && MUL_CYCLES > 1) begin
                        w_state_nxt = ST_MUL;
                    end else begin
                        w_state_nxt = ST_DONE;
                        w_ld        = 1'b1;
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                w_we   = HILO_WE_BOTH;
                                w_data = f_mul(src_a, src_b, w_sgn_in);
                            end
                            OP_MTHI: begin
                                w_we   = HILO_WE_HI;
                                w_data = {src_a, hilo_cur[DATA_W-1:0]};
                            end
                            OP_MTLO: begin
                                w_we   = HILO_WE_LO;
                                w_data = {hilo_cur[2*DATA_W-1:DATA_W], src_a};
                            end
                            default: begin
                                w_we   = HILO_WE_NONE;
                                w_data = hilo_cur;
                            end
                        endcase
                    end
                end
            end
            ST_MUL: begin
                if (r_cnt == MUL_LAST) begin
                    w_state_nxt = ST_DONE;
                    w_ld        = 1'b1;
                    w_we        = HILO_WE_BOTH;
                    w_data      = f_mul(r_a, r_b, r_signed);
                end
            end
            ST_DIV: begin
                if (r_cnt == DIV_LAST) w_state_nxt = ST_FIX;
            end
            ST_FIX: begin
                w_state_nxt = ST_DONE;
                w_ld        = 1'b1;
                w_we        = HILO_WE_BOTH;
                w_data      = (r_b == '0) ? {r_a, {DATA_W{1'b1}}} : {w_r, w_q};
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = ST_IDLE;
            w_ld        = 1'b0;
            w_we        = HILO_WE_NONE;
            w_data      = '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Operand latch, iteration counter and divide datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (start) begin
                        r_a      <= src_a;
                        r_b      <= src_b;
                        r_signed <= w_sgn_in;
                        r_rem    <= '0;
                        r_quo    <= w_a_mag;
                        r_dvs    <= w_b_mag;
                    end
                end
                ST_MUL: r_cnt <= r_cnt + 8'd1;
                ST_DIV: begin
                    r_cnt <= r_cnt + 8'd1;
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    // Registered result: valid only in the DONE cycle, cleared otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done <= 1'b0;
            r_we   <= HILO_WE_NONE;
            r_data <= '0;
        end else begin
            r_done <= w_ld;
            r_we   <= w_we;
            r_data <= w_data;
        end
    end

    assign busy      = (r_state == ST_MUL) || (r_state == ST_DIV) || (r_state == ST_FIX);
    assign stall_req = start | busy;
    assign done      = r_done;
    assign hilo_we   = r_we;
    assign hilo_data = r_data;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed spec cases plus random ops,
// checked every cycle against a latency/arithmetic reference model.
module tb_hilo_muldiv_unit;

    localparam int MULC = 2;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic [63:0] hilo_cur;
    logic        stall_req, busy, done;
    logic [1:0]  hilo_we;
    logic [63:0] hilo_data;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    hilo_muldiv_unit #(.DATA_W(32), .MUL_CYCLES(MULC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .hilo_cur(hilo_cur), .flush(flush),
        .stall_req(stall_req), .busy(busy), .done(done),
        .hilo_we(hilo_we), .hilo_data(hilo_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_lat(input logic [2:0] o);
        case (o)
            3'd0, 3'd1: return MULC;
            3'd2, 3'd3: return 34;
            default:    return 1;
        endcase
    endfunction

    function automatic logic [1:0] model_we(input logic [2:0] o);
        case (o)
            3'd0, 3'd1, 3'd2, 3'd3: return 2'b11;
            3'd4:    return 2'b10;
            3'd5:    return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [63:0] model_res(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] cur);
        longint      sa, sb;
        logic [63:0] ua, ub;
        logic [31:0] q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            3'd0: return 64'(sa * sb);
            3'd1: return ua * ub;
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = 32'(sa / sb);
                r = 32'(sa % sb);
                return {r, q};
            end
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = a / b;
                r = a % b;
                return {r, q};
            end
            3'd4:    return {a, cur[31:0]};
            3'd5:    return {cur[63:32], a};
            default: return cur;
        endcase
    endfunction

    // Reference model: an accepted op becomes a pending result due a fixed
    // number of cycles later; reset and flush discard it.
    bit          m_act = 1'b0;
    int          m_left = 0;
    logic [63:0] m_res = '0;
    logic [1:0]  m_we = '0;

    always @(posedge clk) begin
        if (reset || flush) begin
            m_act  <= 1'b0;
            m_left <= 0;
        end else if (m_act) begin
            if (m_left == 0) m_act <= 1'b0;
            else             m_left <= m_left - 1;
        end else if (start) begin
            m_act  <= 1'b1;
            m_left <= model_lat(op) - 1;
            m_res  <= model_res(op, src_a, src_b, hilo_cur);
            m_we   <= model_we(op);
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic e_busy, e_done;
            e_busy = m_act && (m_left > 0);
            e_done = m_act && (m_left == 0);
            chk("busy", 64'(busy), 64'(e_busy));
            chk("done", 64'(done), 64'(e_done));
            chk("hilo_we", 64'(hilo_we), 64'(e_done ? m_we : 2'b00));
            chk("stall_req", 64'(stall_req), 64'(start | e_busy));
            if (e_done) chk("hilo_data", hilo_data, m_res);
        end
    end

    // Issue one op, wait (bounded) for done, return its result and latency.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] cur, output logic [63:0] d,
                         output logic [1:0] we, output int lat);
        start = 1'b1; op = o; src_a = a; src_b = b; hilo_cur = cur;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); src_a = $urandom; src_b = $urandom;
        hilo_cur = {$urandom, $urandom};
        lat = 1;
        while (!done && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) begin
            errors++;
            $display("FAIL timeout: op %0d got no done within %0d cycles", o, lat);
        end
        d  = hilo_data;
        we = hilo_we;
        @(posedge clk); #1;
    endtask

    logic [63:0] d;
    logic [1:0]  we;
    int          lat, ndone;

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0;
        src_a = '0; src_b = '0; hilo_cur = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_we", 64'(hilo_we), 64'd0);
        chk("rst_data", hilo_data, 64'd0);
        reset = 1'b0;
        chk_en = 1'b1;

        do_op(3'd0, 32'hFFFF_FFFE, 32'd3, 64'd0, d, we, lat);
        chk("mult_lat", 64'(lat), 64'd2);
        chk("mult_we", 64'(we), 64'b11);
        chk("mult_data", d, 64'hFFFF_FFFF_FFFF_FFFA);

        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, d, we, lat);
        chk("multu_data", d, 64'hFFFF_FFFE_0000_0001);

        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 64'd0, d, we, lat);
        chk("div_lat", 64'(lat), 64'd34);
        chk("div_data", d, 64'hFFFF_FFFF_FFFF_FFFD);

        do_op(3'd3, 32'd7, 32'd0, 64'd0, d, we, lat);
        chk("divu0_lat", 64'(lat), 64'd34);
        chk("divu0_data", d, 64'h0000_0007_FFFF_FFFF);

        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, d, we, lat);
        chk("div_ovf_data", d, 64'h0000_0000_8000_0000);

        do_op(3'd4, 32'h1234_5678, 32'd0, 64'hAAAA_AAAA_BBBB_BBBB, d, we, lat);
        chk("mthi_lat", 64'(lat), 64'd1);
        chk("mthi_we", 64'(we), 64'b10);
        chk("mthi_data", d, 64'h1234_5678_BBBB_BBBB);

        do_op(3'd5, 32'h1234_5678, 32'd0, 64'hAAAA_AAAA_BBBB_BBBB, d, we, lat);
        chk("mtlo_we", 64'(we), 64'b01);
        chk("mtlo_data", d, 64'hAAAA_AAAA_1234_5678);

        do_op(3'd6, 32'h1, 32'h2, 64'h0123_4567_89AB_CDEF, d, we, lat);
        chk("unk_lat", 64'(lat), 64'd1);
        chk("unk_we", 64'(we), 64'b00);

        // Flush a divide at cycle 10: no done ever, then a multiply runs cleanly.
        start = 1'b1; op = 3'd2; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("flush_no_done", 64'(ndone), 64'd0);
        do_op(3'd0, 32'd6, 32'hFFFF_FFF9, 64'd0, d, we, lat);
        chk("post_flush_mult", d, 64'hFFFF_FFFF_FFFF_FFD6);

        // Flush in the start cycle: op not accepted.
        start = 1'b1; flush = 1'b1; op = 3'd4; src_a = 32'h55;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            if (done || busy) ndone++;
            @(posedge clk); #1;
        end
        chk("flush_start_ignored", 64'(ndone), 64'd0);

        // Reset at cycle 5 of a divide.
        start = 1'b1; op = 3'd3; src_a = 32'd1000; src_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_done", 64'(done), 64'd0);
        chk("rst_mid_we", 64'(hilo_we), 64'd0);
        chk("rst_mid_data", hilo_data, 64'd0);
        chk("rst_mid_stall", 64'(stall_req), 64'd0);
        repeat (2) @(posedge clk);
        #1;

        // Random ops, including zero divisors and small operands.
        for (int n = 0; n < 250; n++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = $urandom_range(0, 50); rb = $urandom_range(1, 9); end
                2: begin ra = -$urandom_range(0, 50); rb = $urandom_range(1, 9); end
                3: rb = -$urandom_range(1, 9);
                default: ;
            endcase
            do_op(ro, ra, rb, {$urandom, $urandom}, d, we, lat);
            chk("rand_lat", 64'(lat), 64'(model_lat(ro)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
